// File: rtl/input_sram_loader.sv
// Streams valid/ready words into the M1 and M3 input SRAMs at matching addresses,
// then holds Top's start until Top reports done, so back-to-back runs can be chained.
module input_sram_loader #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_req,
  input  logic [ADDR_W:0]   word_count,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              M1_WriteEnable,
  output logic [ADDR_W-1:0] M1_WriteAddress,
  output logic [DATA_W-1:0] M1_WriteBus,
  output logic              M3_WriteEnable,
  output logic [ADDR_W-1:0] M3_WriteAddress,
  output logic [DATA_W-1:0] M3_WriteBus,
  output logic              top_start,
  input  logic              top_done,
  output logic              busy,
  output logic              load_done,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, ARMED} state_t;

  localparam logic [ADDR_W:0]   CAP      = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   WL_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     wl_q, wl_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   wa_q, wa_d;
  logic [DATA_W-1:0]   wd_q, wd_d;
  logic                done_q, done_d;
  logic [ADDR_W:0]     cnt_clamped;
  logic [ADDR_W:0]     wl_inc;

  // Requests beyond SRAM capacity are clamped so the address never wraps.
  assign cnt_clamped = (word_count > CAP) ? CAP : word_count;
  assign wl_inc      = wl_q + WL_ONE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wl_d    = wl_q;
    we_d    = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_req) begin
          cnt_d  = cnt_clamped;
          addr_d = '0;
          wl_d   = '0;
          if (cnt_clamped == '0) begin
            state_d = ARMED;
            done_d  = 1'b1;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (s_valid) begin
          we_d   = 1'b1;
          wa_d   = addr_q;
          wd_d   = s_data;
          addr_d = addr_q + ADDR_ONE;
          wl_d   = wl_inc;
          // Final word: its write lands in FLUSH, alongside the done pulse.
          if (wl_inc == cnt_q) begin
            state_d = FLUSH;
            done_d  = 1'b1;
          end
        end
      end
      FLUSH: state_d = ARMED;
      ARMED: begin
        if (top_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wl_q    <= '0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wl_q    <= wl_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      done_q  <= done_d;
    end
  end

  assign s_ready         = (state_q == LOAD);
  assign busy            = (state_q != IDLE);
  assign top_start       = (state_q == ARMED);
  assign load_done       = done_q;
  assign words_loaded    = wl_q;
  assign M1_WriteEnable  = we_q;
  assign M1_WriteAddress = wa_q;
  assign M1_WriteBus     = wd_q;
  assign M3_WriteEnable  = we_q;
  assign M3_WriteAddress = wa_q;
  assign M3_WriteBus     = wd_q;

endmodule

// File: tb/tb_input_sram_loader.sv
// Scoreboard bench for input_sram_loader: the driver queues each expected SRAM write,
// a negedge monitor pops and compares whenever the write strobe is seen.
module tb_input_sram_loader;
  localparam int DATA_W = 128;
  localparam int ADDR_W = 16;

  logic              clock = 1'b0;
  logic              reset;
  logic              load_req;
  logic [ADDR_W:0]   word_count;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              M1_WriteEnable, M3_WriteEnable;
  logic [ADDR_W-1:0] M1_WriteAddress, M3_WriteAddress;
  logic [DATA_W-1:0] M1_WriteBus, M3_WriteBus;
  logic              top_start, top_done, busy, load_done;
  logic [ADDR_W:0]   words_loaded;

  input_sram_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .load_req(load_req), .word_count(word_count),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .M1_WriteEnable(M1_WriteEnable), .M1_WriteAddress(M1_WriteAddress), .M1_WriteBus(M1_WriteBus),
    .M3_WriteEnable(M3_WriteEnable), .M3_WriteAddress(M3_WriteAddress), .M3_WriteBus(M3_WriteBus),
    .top_start(top_start), .top_done(top_done), .busy(busy),
    .load_done(load_done), .words_loaded(words_loaded)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;
  int  writes_seen = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the head of the expected queue on both ports.
  always @(negedge clock) begin
    if (reset === 1'b0) begin
      if (M1_WriteEnable === 1'b1 || M3_WriteEnable === 1'b1) begin
        writes_seen++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write actual=addr %0h required=no write", M1_WriteAddress);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          if (M1_WriteEnable !== 1'b1 || M3_WriteEnable !== 1'b1 ||
              M1_WriteAddress !== e.a || M3_WriteAddress !== e.a ||
              M1_WriteBus !== e.d || M3_WriteBus !== e.d) begin
            bad++;
            $display("FAIL write actual=we%b%b a%0h/%0h d%0h/%0h required=a%0h d%0h",
                     M1_WriteEnable, M3_WriteEnable, M1_WriteAddress, M3_WriteAddress,
                     M1_WriteBus, M3_WriteBus, e.a, e.d);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_load(input logic [ADDR_W:0] n);
    tick();
    load_req   = 1'b1;
    word_count = n;
    tick();
    load_req   = 1'b0;
  endtask

  // Streams words first..first+n-1; optional one-cycle s_valid gap between words.
  task automatic stream(input int first, input int n, input bit gappy, input logic [DATA_W-1:0] base);
    for (int i = first; i < first + n; i++) begin
      logic hs;
      int   guard;
      wr_t  e;
      s_valid = 1'b1;
      s_data  = base + DATA_W'(i);
      e.a = ADDR_W'(i);
      e.d = base + DATA_W'(i);
      exp_q.push_back(e);
      hs = 1'b0;
      guard = 0;
      while (!hs && guard < 16) begin
        @(negedge clock);
        hs = s_ready;
        tick();
        guard++;
      end
      if (!hs) begin
        total++;
        bad++;
        $display("FAIL handshake_timeout actual=no s_ready required=s_ready word %0d", i);
      end
      s_valid = 1'b0;
      if (gappy && i != first + n - 1) tick();
    end
    s_valid = 1'b0;
  endtask

  // Called right after the last handshake edge: FLUSH cycle, then first ARMED cycle.
  task automatic flush_check(input string tag, input logic [ADDR_W:0] n, input logic [ADDR_W-1:0] last_a);
    @(negedge clock);
    check({tag, "_flush_done"}, DATA_W'({load_done, M1_WriteEnable, s_ready, top_start}), DATA_W'(4'b1100));
    check({tag, "_flush_addr"}, DATA_W'(M1_WriteAddress), DATA_W'(last_a));
    check({tag, "_words"}, DATA_W'(words_loaded), DATA_W'(n));
    @(negedge clock);
    check({tag, "_armed"}, DATA_W'({top_start, busy, load_done, M1_WriteEnable}), DATA_W'(4'b1100));
  endtask

  task automatic finish_top(input string tag);
    tick();
    top_done = 1'b1;
    tick();
    top_done = 1'b0;
    @(negedge clock);
    check({tag, "_idle"}, DATA_W'({top_start, busy}), DATA_W'(2'b00));
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; load_req = 1'b0; word_count = '0; s_valid = 1'b0; s_data = '0; top_done = 1'b0;
    repeat (2) @(negedge clock);
    check("reset_ctrl", DATA_W'({s_ready, M1_WriteEnable, M3_WriteEnable, top_start, busy, load_done}), '0);
    check("reset_bus", M1_WriteBus | M3_WriteBus, '0);
    check("reset_addr_words", DATA_W'({M1_WriteAddress, M3_WriteAddress, words_loaded}), '0);
    @(posedge clock); #1 reset = 1'b0;

    // Four words, continuous valid.
    start_load(4);
    check("t1_ready", DATA_W'({s_ready, busy}), DATA_W'(2'b11));
    stream(0, 4, 1'b0, 128'h0);
    flush_check("t1", 4, 16'd3);
    finish_top("t1");

    // Three words with gaps.
    start_load(3);
    stream(0, 3, 1'b1, 128'hA5A5_0000_0000_0000_0000_0000_0000_0010);
    flush_check("t2", 3, 16'd2);
    finish_top("t2");

    // Zero words: straight to ARMED, done honoured on first ARMED cycle.
    start_load(0);
    top_done = 1'b1;
    @(negedge clock);
    check("t3_armed", DATA_W'({top_start, load_done, busy, M1_WriteEnable}), DATA_W'(4'b1110));
    tick();
    top_done = 1'b0;
    @(negedge clock);
    check("t3_idle", DATA_W'({top_start, busy, load_done}), DATA_W'(3'b000));

    // Oversized request is clamped to full capacity.
    start_load(17'h1FFFF);
    stream(0, 65536, 1'b0, 128'hC0DE_0000_0000_0000_0000_0000_0000_0000);
    flush_check("t4", 17'h10000, 16'hFFFF);
    finish_top("t4");

    // Reset mid-load after two of eight words.
    start_load(8);
    stream(0, 2, 1'b0, 128'h77);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("t5_reset_ctrl", DATA_W'({s_ready, M1_WriteEnable, M3_WriteEnable, top_start, busy, load_done}), '0);
    check("t5_reset_addr", DATA_W'({M1_WriteAddress, words_loaded}), '0);
    @(posedge clock); #1 reset = 1'b0;
    start_load(2);
    stream(0, 2, 1'b0, 128'h900);
    flush_check("t5b", 2, 16'd1);
    finish_top("t5b");

    // load_req during LOAD and ARMED is ignored.
    start_load(3);
    stream(0, 1, 1'b0, 128'h500);
    load_req = 1'b1; word_count = 17'd10;
    tick();
    load_req = 1'b0;
    stream(1, 2, 1'b0, 128'h500);
    flush_check("t6", 3, 16'd2);
    tick();
    load_req = 1'b1; word_count = 17'd5;
    tick();
    load_req = 1'b0;
    @(negedge clock);
    check("t6_armed_ignore", DATA_W'({top_start, busy, s_ready}), DATA_W'(3'b110));
    check("t6_words_hold", DATA_W'(words_loaded), DATA_W'(3));
    finish_top("t6");
    start_load(2);
    stream(0, 2, 1'b0, 128'h600);
    flush_check("t6b", 2, 16'd1);
    finish_top("t6b");

    repeat (3) @(negedge clock);
    check("queue_drained", DATA_W'(exp_q.size()), '0);
    check("write_total", DATA_W'(writes_seen), DATA_W'(4 + 3 + 65536 + 2 + 2 + 3 + 2));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/input_sram_loader.md
Name: input_sram_loader

Overview:
- Upstream stage of Top: fills the input SRAMs (M1 and M3, sram_2R1W instances) from a 128-bit valid/ready word stream, then raises Top's start.
- Writes every accepted word to the same address in both M1 and M3; both memories always hold identical input images.
- Replaces file preloading for streamed input and allows back-to-back runs: load, start, wait for done, reload.

Parameters:
- DATA_W, 128, stream word and SRAM write-bus width
- ADDR_W, 16, SRAM address width; capacity 2^ADDR_W words

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- load_req  in  1  one-cycle request to begin a load; sampled only in IDLE
- word_count  in  ADDR_W+1  words to load; latched with load_req
- s_valid  in  1  stream word valid
- s_data  in  DATA_W  stream word
- s_ready  out  1  loader accepts s_data this cycle
- M1_WriteEnable  out  1  M1 write strobe
- M1_WriteAddress  out  ADDR_W  M1 write address
- M1_WriteBus  out  DATA_W  M1 write data
- M3_WriteEnable  out  1  M3 write strobe
- M3_WriteAddress  out  ADDR_W  M3 write address
- M3_WriteBus  out  DATA_W  M3 write data
- top_start  out  1  start level to Top
- top_done  in  1  Top completion indication
- busy  out  1  high whenever state is not IDLE
- load_done  out  1  one-cycle pulse when the final word has been written
- words_loaded  out  ADDR_W+1  words written in the current/last load

Behaviour:
- Reset (async, active-high): state=IDLE. All outputs 0: s_ready, both WEs, addresses, buses, top_start, busy, load_done, words_loaded.
- Single clock domain; no combinational path from s_valid to s_ready. s_ready is a registered state decode.
- States: IDLE, LOAD, FLUSH, ARMED.
- IDLE:
  - On load_req=1: latch cnt=min(word_count, 2^ADDR_W); clear address counter and words_loaded.
  - cnt>0 -> LOAD. cnt==0 -> ARMED directly, with a load_done pulse in the same transition.
- LOAD:
  - s_ready=1.
  - A handshake (s_valid&s_ready at edge k) registers the word. During cycle k+1, M1/M3 WE=1, Address=addr, Bus=data; the SRAM captures it at edge k+1.
  - addr and words_loaded increment by 1 per handshake.
  - A stalled s_valid inserts WE=0 cycles; no address advance.
  - On the handshake of word cnt-1: s_ready drops the next cycle -> FLUSH.
- FLUSH: exactly one cycle, carrying the final write (WE=1). load_done=1 in this cycle. -> ARMED.
- ARMED:
  - top_start=1, held until top_done is sampled 1; then top_start=0 on the next cycle -> IDLE.
  - top_done=1 on the first ARMED cycle is honoured.
- M1 and M3 write ports are driven bit-identically every cycle. WE=0 outside write cycles; address and bus hold their last value.
- Address wrap: cnt is clamped, so the address counter never exceeds 2^ADDR_W-1. For cnt=2^ADDR_W, the last write is at 0xFFFF.
- load_req outside IDLE is ignored; word_count changes after latching are ignored.
- top_done outside ARMED is ignored.
- Reset mid-load: outputs clear immediately (async). Memory contents written so far persist (owned by the SRAM). The next load restarts at address 0.

Test Plan:
- Reset, load_req with word_count=4, words 0x..01..0x..04 streamed with s_valid continuous -> WE high 4 consecutive cycles at addresses 0..3 in both M1 and M3. load_done pulses on the 4th WE cycle. top_start rises the next cycle. words_loaded=4.
- word_count=3, s_valid toggled 1,0,1,0,1 -> exactly 3 writes at addresses 0,1,2; no WE during gaps; memory dump equals the input words.
- word_count=0 -> no WE ever; load_done pulse; top_start=1 one cycle after load_req; top_done=1 -> top_start=0 and busy=0 next cycle.
- word_count=0x1FFFF (above capacity) -> clamped to 65536 writes, final address 0xFFFF, words_loaded=0x10000, no wrap to address 0.
- Assert reset after 2 of 8 words -> all outputs 0 immediately. A new load of 2 words writes addresses 0,1.
- load_req pulsed while in LOAD and while in ARMED -> ignored, cnt unchanged. Second load after top_done completes normally, with Top's start re-asserted.
